// File: rtl/rv_mem_stage.sv
// Memory stage of the RV32I pipeline: drives data memory over a req/gnt/rvalid
// handshake, formats store lanes, extends load data, forwards the pre-selected
// result to EX and loads the MEM/WB registers (bubbles while stalled).
// Optional feature macro: RV_MEM_MISALIGN_TRAP_EN (misaligned accesses are
// suppressed and flagged on o_mem_misalign instead of being address-masked).
module rv_mem_stage #(
  parameter int unsigned BW_DATA = 32
) (
  input  logic               i_mem_clk,
  input  logic               i_mem_rst,
  input  logic               i_mem_is_load,
  input  logic               i_mem_dmem_we,
  input  logic [BW_DATA-1:0] i_mem_alu_res,
  input  logic [BW_DATA-1:0] i_mem_ext_imm,
  input  logic [BW_DATA-1:0] i_mem_pc_plus_4,
  input  logic [BW_DATA-1:0] i_mem_dmem_wd,
  input  logic [2:0]         i_mem_dmem_bytectrl,
  input  logic               i_mem_rf_we,
  input  logic [4:0]         i_mem_rf_wa,
  input  logic [1:0]         i_mem_rf_wd_pre_sel,
  output logic               o_mem_stall,
  output logic [BW_DATA-1:0] o_mem_fwd_data,
  output logic               o_mem_dmem_req,
  output logic               o_mem_dmem_we,
  output logic [BW_DATA-1:0] o_mem_dmem_addr,
  output logic [3:0]         o_mem_dmem_be,
  output logic [BW_DATA-1:0] o_mem_dmem_wdata,
  input  logic               i_mem_dmem_gnt,
  input  logic               i_mem_dmem_rvalid,
  input  logic [BW_DATA-1:0] i_mem_dmem_rdata,
`ifdef RV_MEM_MISALIGN_TRAP_EN
  output logic               o_mem_misalign,
`endif
  output logic               o_mem_wb_rf_we,
  output logic [4:0]         o_mem_wb_rf_wa,
  output logic               o_mem_wb_is_load,
  output logic [BW_DATA-1:0] o_mem_wb_rf_wd_pre,
  output logic [BW_DATA-1:0] o_mem_wb_load_data
);

  localparam int unsigned BW_EXT_B = BW_DATA - 8;
  localparam int unsigned BW_EXT_H = BW_DATA - 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               size_b;
  logic               size_h;
  logic               is_unsigned;
  logic [1:0]         lane_off;
  logic               misalign_c;
  logic               mem_op;
  logic               done;
  logic               req_c;
  logic [BW_DATA-1:0] rdata_shift;
  logic [BW_DATA-1:0] load_ext;

  // Access decode: size, naturally aligned lane offset, misalignment
  always_comb begin
    size_b      = (i_mem_dmem_bytectrl[1:0] == 2'b00);
    size_h      = (i_mem_dmem_bytectrl[1:0] == 2'b01);
    is_unsigned = i_mem_dmem_bytectrl[2];
    if (size_b)      lane_off = i_mem_alu_res[1:0];
    else if (size_h) lane_off = {i_mem_alu_res[1], 1'b0};
    else             lane_off = 2'b00;
`ifdef RV_MEM_MISALIGN_TRAP_EN
    misalign_c = (i_mem_is_load | i_mem_dmem_we) &
                 ((size_h & i_mem_alu_res[0]) | (~size_b & ~size_h & (|i_mem_alu_res[1:0])));
`else
    misalign_c = 1'b0;
`endif
    mem_op = (i_mem_is_load | i_mem_dmem_we) & ~misalign_c;
  end

  // Store lane formatting and bus address
  always_comb begin
    o_mem_dmem_addr = i_mem_alu_res;
    o_mem_dmem_we   = i_mem_dmem_we & mem_op;
    if (size_b) begin
      o_mem_dmem_be    = 4'b0001 << lane_off;
      o_mem_dmem_wdata = {4{i_mem_dmem_wd[7:0]}};
    end else if (size_h) begin
      o_mem_dmem_be    = 4'b0011 << lane_off;
      o_mem_dmem_wdata = {2{i_mem_dmem_wd[15:0]}};
    end else begin
      o_mem_dmem_be    = 4'b1111;
      o_mem_dmem_wdata = i_mem_dmem_wd;
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    rdata_shift = i_mem_dmem_rdata >> {lane_off, 3'b000};
    if (size_b)
      load_ext = {{BW_EXT_B{~is_unsigned & rdata_shift[7]}}, rdata_shift[7:0]};
    else if (size_h)
      load_ext = {{BW_EXT_H{~is_unsigned & rdata_shift[15]}}, rdata_shift[15:0]};
    else
      load_ext = i_mem_dmem_rdata;
  end

  // Result pre-selection forwarded to EX
  always_comb begin
    case (i_mem_rf_wd_pre_sel)
      2'b01:   o_mem_fwd_data = i_mem_ext_imm;
      2'b10:   o_mem_fwd_data = i_mem_pc_plus_4;
      default: o_mem_fwd_data = i_mem_alu_res;
    endcase
  end

  // Handshake FSM state register
  always_ff @(posedge i_mem_clk) begin
    if (i_mem_rst) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Handshake FSM next state, request and stall
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          req_c   = 1'b1;
          state_d = i_mem_dmem_gnt ? ST_WAIT_R : ST_REQ;
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (i_mem_dmem_gnt) state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        done = i_mem_dmem_rvalid;
        if (i_mem_dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    o_mem_dmem_req = req_c & ~i_mem_rst;
    o_mem_stall    = mem_op & ~done & ~i_mem_rst;
  end

  // MEM/WB registers: bubble while stalled, capture on release
  always_ff @(posedge i_mem_clk) begin
    if (i_mem_rst) begin
      o_mem_wb_rf_we     <= 1'b0;
      o_mem_wb_rf_wa     <= 5'd0;
      o_mem_wb_is_load   <= 1'b0;
      o_mem_wb_rf_wd_pre <= '0;
      o_mem_wb_load_data <= '0;
`ifdef RV_MEM_MISALIGN_TRAP_EN
      o_mem_misalign     <= 1'b0;
`endif
    end else if (o_mem_stall) begin
      o_mem_wb_rf_we   <= 1'b0;
      o_mem_wb_is_load <= 1'b0;
`ifdef RV_MEM_MISALIGN_TRAP_EN
      o_mem_misalign   <= 1'b0;
`endif
    end else begin
      o_mem_wb_rf_we     <= i_mem_rf_we & ~(i_mem_is_load & misalign_c);
      o_mem_wb_rf_wa     <= i_mem_rf_wa;
      o_mem_wb_is_load   <= i_mem_is_load;
      o_mem_wb_rf_wd_pre <= o_mem_fwd_data;
      o_mem_wb_load_data <= load_ext;
`ifdef RV_MEM_MISALIGN_TRAP_EN
      o_mem_misalign     <= misalign_c;
`endif
    end
  end

endmodule
